// File: rtl/btn_pulse_gen.sv
// Button conditioner: 2-FF synchronizer, debounce counter and a 4-state FSM that
// emit a one-cycle press pulse plus a debounced level. Define AUTO_REPEAT_EN for hold-to-repeat.
module btn_pulse_gen #(
    parameter int DEB_CYCLES    = 50000,
    parameter int CNT_W         = 16,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int RPT_W         = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse_out,
    output logic btn_level
);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] LP_DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    // Reject parameter sets that would let a counter wrap or a window collapse.
    if (DEB_CYCLES < 2) begin : g_badDebCycles
        $error("btn_pulse_gen: DEB_CYCLES must be 2 or more");
    end
    if ((64'd1 << CNT_W) <= 64'(DEB_CYCLES)) begin : g_badCntW
        $error("btn_pulse_gen: CNT_W too narrow for DEB_CYCLES");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_badRepeat
        $error("btn_pulse_gen: REPEAT_DELAY and REPEAT_PERIOD must be positive");
    end
    if ((64'd1 << RPT_W) <= 64'(REPEAT_DELAY) || (64'd1 << RPT_W) <= 64'(REPEAT_PERIOD)) begin : g_badRptW
        $error("btn_pulse_gen: RPT_W too narrow for repeat timing");
    end

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_pulse;
    logic             r_level;
    logic             w_pulseNext;
    logic             w_levelNext;
    logic             w_pressDone;
    logic             w_releaseDone;
    logic             w_rptFire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_cntNext;
        end
    end

    // A sample that disagrees with the debounce direction drops back and restarts the window.
    always_comb begin
        w_nextState = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_nextState = DEB_PRESS;
                    w_cntNext   = '0;
                end
            end
            DEB_PRESS: begin
                if (!r_sync2) begin
                    w_nextState = IDLE;
                end else if (r_cnt == LP_DEB_LAST) begin
                    w_nextState = HELD;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_nextState = DEB_RELEASE;
                    w_cntNext   = '0;
                end
            end
            DEB_RELEASE: begin
                if (r_sync2) begin
                    w_nextState = HELD;
                end else if (r_cnt == LP_DEB_LAST) begin
                    w_nextState = IDLE;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    assign w_pressDone   = (r_state == DEB_PRESS)   &&  r_sync2 && (r_cnt == LP_DEB_LAST);
    assign w_releaseDone = (r_state == DEB_RELEASE) && !r_sync2 && (r_cnt == LP_DEB_LAST);

    always_comb begin
        w_pulseNext = w_pressDone | w_rptFire;
        w_levelNext = r_level;
        if (w_pressDone) begin
            w_levelNext = 1'b1;
        end else if (w_releaseDone) begin
            w_levelNext = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pulse <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_pulse <= w_pulseNext;
            r_level <= w_levelNext;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [RPT_W-1:0] LP_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] LP_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] r_rptCnt;
    logic [RPT_W-1:0] w_rptCntNext;
    logic             r_rptPeriodic;
    logic             w_rptPeriodicNext;

    // The first repeat waits the long delay; later ones use the shorter period.
    // Only counts on edges that stay in HELD, so the press pulse can never coincide.
    always_comb begin
        w_rptFire         = 1'b0;
        w_rptCntNext      = '0;
        w_rptPeriodicNext = 1'b0;
        if (r_state == HELD && w_nextState == HELD) begin
            if (r_rptCnt == (r_rptPeriodic ? LP_PERIOD_LAST : LP_DELAY_LAST)) begin
                w_rptFire         = 1'b1;
                w_rptPeriodicNext = 1'b1;
            end else begin
                w_rptCntNext      = r_rptCnt + RPT_W'(1);
                w_rptPeriodicNext = r_rptPeriodic;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rptCnt      <= '0;
            r_rptPeriodic <= 1'b0;
        end else begin
            r_rptCnt      <= w_rptCntNext;
            r_rptPeriodic <= w_rptPeriodicNext;
        end
    end
`else
    assign w_rptFire = 1'b0;
`endif

    assign pulse_out = r_pulse;
    assign btn_level = r_level;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Self-checking bench for btn_pulse_gen: directed test-plan steps plus random runs,
// compared every cycle against a run-length reference model of the debounce rules.
module tb_btn_pulse_gen;

    localparam int DEB = 4;
    localparam int DLY = 8;
    localparam int PER = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic btn_in = 1'b0;
    logic pulse_out;
    logic btn_level;

    int checks   = 0;
    int failures = 0;
    int edgeNum  = 0;

    // Reference model: the level flips once DEB+1 consecutive synchronized samples disagree with it.
    bit mS1, mS2, mLevel, mPulse;
    int mRun, mHeldSince;

    int  dutPulses;
    int  firstPulseEdge;
    int  fallEdge;
    logic prevLevel;

    btn_pulse_gen #(
        .DEB_CYCLES   (DEB),
        .CNT_W        (4),
        .REPEAT_DELAY (DLY),
        .REPEAT_PERIOD(PER),
        .RPT_W        (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .pulse_out(pulse_out),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mS1 = 1'b0; mS2 = 1'b0; mLevel = 1'b0; mPulse = 1'b0;
        mRun = 0; mHeldSince = 0;
    endtask

    task automatic modelEdge(input bit b);
        bit s2;
        s2     = mS2;
        mPulse = 1'b0;
        if (s2 != mLevel) begin
            mRun++;
            if (mRun == DEB + 1) begin
                mLevel     = s2;
                mPulse     = s2;
                mRun       = 0;
                mHeldSince = edgeNum;
            end
        end else begin
            if (mLevel && mRun > 0) mHeldSince = edgeNum;
`ifdef AUTO_REPEAT_EN
            else if (mLevel) begin
                int age;
                age = edgeNum - mHeldSince;
                if (age >= DLY && (age - DLY) % PER == 0) mPulse = 1'b1;
            end
`endif
            mRun = 0;
        end
        mS2 = mS1;
        mS1 = b;
    endtask

    task automatic clearTrack();
        dutPulses      = 0;
        firstPulseEdge = -1;
        fallEdge       = -1;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (pulse_out === mPulse) else begin
            failures++;
            $error("[TB] FAIL %s pulse_out got=%0b exp=%0b edge=%0d", tag, pulse_out, mPulse, edgeNum);
        end
        checks++;
        assert (btn_level === mLevel) else begin
            failures++;
            $error("[TB] FAIL %s btn_level got=%0b exp=%0b edge=%0d", tag, btn_level, mLevel, edgeNum);
        end
        if (pulse_out === 1'b1) begin
            dutPulses++;
            if (firstPulseEdge < 0) firstPulseEdge = edgeNum;
        end
        if (btn_level === 1'b0 && prevLevel === 1'b1 && fallEdge < 0) fallEdge = edgeNum;
        prevLevel = btn_level;
    endtask

    task automatic checkValue(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            failures++;
            $error("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit b, input string tag);
        @(negedge clk);
        btn_in = b;
        rst    = 1'b1;
        @(posedge clk);
        edgeNum++;
        modelEdge(b);
        #1;
        checkOutput(tag);
    endtask

    task automatic applyRun(input bit b, input int len, input string tag);
        for (int i = 0; i < len; i++) applyStimulus(b, tag);
    endtask

    task automatic applyReset(input int cycles, input bit randomBtn);
        @(negedge clk);
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_async");
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            btn_in = randomBtn ? 1'($urandom) : 1'b1;
            @(posedge clk);
            edgeNum++;
            #1;
            checkOutput("rst_hold");
        end
    endtask

    initial begin
        int k, r, m;
        bit bounce [8];
        modelReset();
        clearTrack();
        prevLevel = 1'b0;

        // 1: reset holds outputs low regardless of the button, then idle stays low.
        applyReset(6, 1'b1);
        clearTrack();
        applyRun(1'b0, 10, "idle");
        checkValue("idle_pulses", dutPulses, 0);

        // 2: clean press and release.
        clearTrack();
        k = edgeNum + 1;
        applyRun(1'b1, 20, "clean_press");
        r = edgeNum + 1;
        applyRun(1'b0, 12, "clean_release");
        checkValue("clean_pulse_edge", firstPulseEdge, k + 6);
        checkValue("clean_fall_edge", fallEdge, r + 6);
`ifndef AUTO_REPEAT_EN
        checkValue("clean_pulse_count", dutPulses, 1);
`endif

        // 3: bouncy press settles into a single accepted press.
        clearTrack();
        bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        k = edgeNum + 6;
        for (int i = 0; i < 8; i++) applyStimulus(bounce[i], "bouncy");
        applyRun(1'b1, 8, "bouncy_hold");
        checkValue("bouncy_pulse_edge", firstPulseEdge, k + 6);
        checkValue("bouncy_pulse_count", dutPulses, 1);
        applyRun(1'b0, 12, "bouncy_release");

        // 4: short glitches are rejected in both directions.
        clearTrack();
        applyRun(1'b1, 3, "glitch_hi");
        applyRun(1'b0, 10, "glitch_hi_after");
        checkValue("glitch_hi_pulses", dutPulses, 0);
        applyRun(1'b1, 12, "glitch_press");
        clearTrack();
        applyRun(1'b0, 3, "glitch_lo");
        applyRun(1'b1, 6, "glitch_lo_after");
        checkValue("glitch_lo_pulses", dutPulses, 0);
        checkValue("glitch_lo_level", int'(btn_level), 1);
        applyRun(1'b0, 12, "glitch_release");

        // 5: reset during press debounce, button still held on release.
        clearTrack();
        applyRun(1'b1, 5, "midrst_press");
        checkValue("midrst_no_pulse", dutPulses, 0);
        applyReset(3, 1'b0);
        clearTrack();
        m = edgeNum + 1;
        applyRun(1'b1, 10, "midrst_redo");
        checkValue("midrst_pulse_edge", firstPulseEdge, m + 6);
        applyRun(1'b0, 12, "midrst_release");

        // 6: long hold.
        clearTrack();
        k = edgeNum + 1;
        applyRun(1'b1, 30, "long_hold");
        applyRun(1'b0, 12, "long_release");
        checkValue("long_first_edge", firstPulseEdge, k + 6);
`ifdef AUTO_REPEAT_EN
        checkValue("long_pulse_count", dutPulses, 6);
`else
        checkValue("long_pulse_count", dutPulses, 1);
`endif

        // Random runs, with lengths straddling the debounce window, and a reset midway.
        for (int i = 0; i < 40; i++) begin
            applyRun(1'($urandom), $urandom_range(1, 9), "random");
            if (i == 20) applyReset(2, 1'b1);
        end
        applyRun(1'b0, 12, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
